// File: rtl/s32x_vdp_bus_master.sv
// s32x_vdp_bus_master: turns one arbitrated host request into one or two
// 16-bit VDP bus cycles with chip-select decode, strobe sequencing,
// ACK_N handshake, read-data capture and a no-acknowledge timeout.
module s32x_vdp_bus_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HOST_REQ,
    input  logic        HOST_WE,
    input  logic        HOST_SZ,
    input  logic [1:0]  HOST_SPACE,
    input  logic [16:0] HOST_A,
    input  logic [3:0]  HOST_BE,
    input  logic [31:0] HOST_DI,
    output logic [31:0] HOST_DO,
    output logic        HOST_ACK,
    output logic        HOST_ERR,
    output logic        BUSY,
    output logic [16:0] A,
    output logic [15:0] DO,
    input  logic [15:0] DI,
    output logic        RD_N,
    output logic        LWR_N,
    output logic        UWR_N,
    input  logic        ACK_N,
    output logic        REG_CS_N,
    output logic        PAL_CS_N,
    output logic        DRAM_CS_N
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [16:0]   a_q, a_d;
    logic [15:0]   dout_q, dout_d;
    logic          rd_n_q, rd_n_d;
    logic          lwr_n_q, lwr_n_d;
    logic          uwr_n_q, uwr_n_d;
    logic [2:0]    cs_n_q, cs_n_d;         // {REG, PAL, DRAM}
    logic [31:0]   host_do_q, host_do_d;
    logic          host_ack_q, host_ack_d;
    logic          host_err_q, host_err_d;
    logic          busy_q, busy_d;
    logic          we_q, we_d;
    logic          pend_q, pend_d;         // low-word half still to run
    logic [15:0]   lo_data_q, lo_data_d;
    logic [1:0]    lo_be_q, lo_be_d;
    logic [1:0]    be_q, be_d;             // byte enables of the current half
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;       // read words shifted in per half
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    hi_be;
    logic          hi_live;
    logic          lo_live;
    logic [2:0]    cs_dec;

    // Next-state and next-output computation for the bus sequencer.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        dout_d     = dout_q;
        rd_n_d     = rd_n_q;
        lwr_n_d    = lwr_n_q;
        uwr_n_d    = uwr_n_q;
        cs_n_d     = cs_n_q;
        host_do_d  = host_do_q;
        host_ack_d = 1'b0;
        host_err_d = 1'b0;
        we_d       = we_q;
        pend_d     = pend_q;
        lo_data_d  = lo_data_q;
        lo_be_d    = lo_be_q;
        be_d       = be_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;

        hi_be   = HOST_SZ ? HOST_BE[3:2] : HOST_BE[1:0];
        hi_live = !HOST_WE || (hi_be != 2'b00);
        lo_live = HOST_SZ && (!HOST_WE || (HOST_BE[1:0] != 2'b00));

        case (HOST_SPACE)
            2'b00:   cs_dec = 3'b011;
            2'b01:   cs_dec = 3'b101;
            2'b10:   cs_dec = 3'b110;
            default: cs_dec = 3'b111;
        endcase

        case (state_q)
            S_IDLE: begin
                if (HOST_REQ) begin
                    we_d      = HOST_WE;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    lo_data_d = HOST_DI[15:0];
                    lo_be_d   = HOST_BE[1:0];
                    if (HOST_SPACE == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (!hi_live && !lo_live) begin
                        state_d = S_DONE;
                    end else begin
                        cs_n_d  = cs_dec;
                        state_d = S_SETUP;
                        if (hi_live) begin
                            a_d    = HOST_SZ ? {HOST_A[16:1], 1'b0} : HOST_A;
                            dout_d = HOST_SZ ? HOST_DI[31:16] : HOST_DI[15:0];
                            be_d   = hi_be;
                            pend_d = lo_live;
                        end else begin
                            // High word has no enabled bytes: start directly on the low word.
                            a_d    = {HOST_A[16:1], 1'b1};
                            dout_d = HOST_DI[15:0];
                            be_d   = HOST_BE[1:0];
                            pend_d = 1'b0;
                        end
                    end
                end
            end

            S_SETUP: begin
                if (we_q) begin
                    lwr_n_d = ~be_q[0];
                    uwr_n_d = ~be_q[1];
                end else begin
                    rd_n_d = 1'b0;
                end
                cnt_d   = '0;
                state_d = S_STROBE;
            end

            S_STROBE: begin
                if (!ACK_N) begin
                    if (!we_q) begin
                        rdata_d = {rdata_q[15:0], DI};
                    end
                    rd_n_d  = 1'b1;
                    lwr_n_d = 1'b1;
                    uwr_n_d = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = {rdata_q[15:0], 16'hFFFF};
                    end
                    rd_n_d  = 1'b1;
                    lwr_n_d = 1'b1;
                    uwr_n_d = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                if (ACK_N) begin
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        a_d     = {a_q[16:1], 1'b1};
                        dout_d  = lo_data_q;
                        be_d    = lo_be_q;
                        state_d = S_SETUP;
                    end else begin
                        cs_n_d     = '1;
                        host_ack_d = 1'b1;
                        host_err_d = err_q;
                        host_do_d  = rdata_q;
                        state_d    = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Entered from RELEASE with the ack already raised; entered from IDLE
                // (reserved space or fully skipped write) it raises the ack one cycle later.
                if (host_ack_q) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    host_ack_d = 1'b1;
                    host_err_d = err_q;
                    host_do_d  = rdata_q;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset forces bus idle immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            dout_q     <= '0;
            rd_n_q     <= 1'b1;
            lwr_n_q    <= 1'b1;
            uwr_n_q    <= 1'b1;
            cs_n_q     <= '1;
            host_do_q  <= '0;
            host_ack_q <= 1'b0;
            host_err_q <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            pend_q     <= 1'b0;
            lo_data_q  <= '0;
            lo_be_q    <= '0;
            be_q       <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            rd_n_q     <= rd_n_d;
            lwr_n_q    <= lwr_n_d;
            uwr_n_q    <= uwr_n_d;
            cs_n_q     <= cs_n_d;
            host_do_q  <= host_do_d;
            host_ack_q <= host_ack_d;
            host_err_q <= host_err_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            pend_q     <= pend_d;
            lo_data_q  <= lo_data_d;
            lo_be_q    <= lo_be_d;
            be_q       <= be_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign A         = a_q;
    assign DO        = dout_q;
    assign RD_N      = rd_n_q;
    assign LWR_N     = lwr_n_q;
    assign UWR_N     = uwr_n_q;
    assign REG_CS_N  = cs_n_q[2];
    assign PAL_CS_N  = cs_n_q[1];
    assign DRAM_CS_N = cs_n_q[0];
    assign HOST_DO   = host_do_q;
    assign HOST_ACK  = host_ack_q;
    assign HOST_ERR  = host_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_s32x_vdp_bus_master.sv
// Testbench for s32x_vdp_bus_master: table of host requests against a
// reference responder, with expected bus halves and acks kept in queues.
module tb_s32x_vdp_bus_master;

    logic        CLK;
    logic        RST_N;
    logic        HOST_REQ;
    logic        HOST_WE;
    logic        HOST_SZ;
    logic [1:0]  HOST_SPACE;
    logic [16:0] HOST_A;
    logic [3:0]  HOST_BE;
    logic [31:0] HOST_DI;
    logic [31:0] HOST_DO;
    logic        HOST_ACK;
    logic        HOST_ERR;
    logic        BUSY;
    logic [16:0] A;
    logic [15:0] DO;
    logic [15:0] DI;
    logic        RD_N;
    logic        LWR_N;
    logic        UWR_N;
    logic        ACK_N;
    logic        REG_CS_N;
    logic        PAL_CS_N;
    logic        DRAM_CS_N;

    s32x_vdp_bus_master #(.TIMEOUT(64)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_SZ(HOST_SZ),
        .HOST_SPACE(HOST_SPACE), .HOST_A(HOST_A), .HOST_BE(HOST_BE),
        .HOST_DI(HOST_DI), .HOST_DO(HOST_DO), .HOST_ACK(HOST_ACK),
        .HOST_ERR(HOST_ERR), .BUSY(BUSY), .A(A), .DO(DO), .DI(DI),
        .RD_N(RD_N), .LWR_N(LWR_N), .UWR_N(UWR_N), .ACK_N(ACK_N),
        .REG_CS_N(REG_CS_N), .PAL_CS_N(PAL_CS_N), .DRAM_CS_N(DRAM_CS_N)
    );

    typedef struct {
        logic        we;
        logic        sz;
        logic [1:0]  sp;
        logic [16:0] a;
        logic [3:0]  be;
        logic [31:0] di;
        logic [15:0] d0;
        logic [15:0] d1;
        int          rwait;
        logic        chk_do;
        logic [31:0] exp_do;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [16:0] a;
        logic [15:0] dat;
        logic [2:0]  st;    // {UWR_N, LWR_N, RD_N}
        logic [2:0]  cs;    // {REG, PAL, DRAM}
        logic        ackn;
        int          len;
    } half_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          lat;
    } ack_t;

    int n_pass;
    int n_total;
    int cyc;
    int e0;
    int base;
    int halves_seen;
    int cs_cycles;
    int cs_viol;
    int wcnt;
    int resp_wait;
    logic resp_dead;
    logic [15:0] resp_d0;
    logic [15:0] resp_d1;

    half_t exp_halves[$];
    half_t obs_halves[$];
    ack_t  obs_acks[$];

    logic        prev_low;
    logic [2:0]  prev_cs;
    half_t       snap;
    logic [2:0]  st_now;
    logic [2:0]  cs_now;
    logic        st_low;

    assign st_now = {UWR_N, LWR_N, RD_N};
    assign cs_now = {REG_CS_N, PAL_CS_N, DRAM_CS_N};
    assign st_low = (st_now != 3'b111);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference responder: ACK_N low the edge after a strobe is seen low, high the edge after all are high.
    always @(posedge CLK) begin
        if (!RST_N) begin
            ACK_N <= 1'b1;
            DI    <= '0;
            wcnt  <= 0;
        end else if (!st_low) begin
            ACK_N <= 1'b1;
            wcnt  <= 0;
        end else if (ACK_N && !resp_dead) begin
            if (wcnt < resp_wait) begin
                wcnt <= wcnt + 1;
            end else begin
                ACK_N <= 1'b0;
                DI    <= (halves_seen - base <= 1) ? resp_d0 : resp_d1;
            end
        end
    end

    // Bus and host monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_low <= 1'b0;
            prev_cs  <= 3'b111;
        end else begin
            if (cs_now != 3'b111) cs_cycles <= cs_cycles + 1;
            if (st_low && !prev_low) begin
                halves_seen <= halves_seen + 1;
                snap <= '{A, DO, st_now, cs_now, ACK_N, 1};
            end else if (st_low) begin
                snap.len <= snap.len + 1;
                if (cs_now != prev_cs) cs_viol <= cs_viol + 1;
            end else if (prev_low) begin
                obs_halves.push_back(snap);
            end
            if (HOST_ACK) obs_acks.push_back('{HOST_DO, HOST_ERR, cyc - e0});
            prev_low <= st_low;
            prev_cs  <= cs_now;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Expected bus halves for one request.
    task automatic model_halves(input vec_t v, input int len);
        logic [2:0]  cs;
        logic [1:0]  hb;
        logic [16:0] a0;
        logic [16:0] a1;
        cs = (v.sp == 2'b00) ? 3'b011 : (v.sp == 2'b01) ? 3'b101 : 3'b110;
        a0 = v.sz ? {v.a[16:1], 1'b0} : v.a;
        a1 = {v.a[16:1], 1'b1};
        if (v.sp == 2'b11) return;
        if (!v.we) begin
            exp_halves.push_back('{a0, 16'h0, 3'b110, cs, 1'b1, len});
            if (v.sz) exp_halves.push_back('{a1, 16'h0, 3'b110, cs, 1'b1, len});
        end else begin
            hb = v.sz ? v.be[3:2] : v.be[1:0];
            if (hb != 2'b00)
                exp_halves.push_back('{a0, v.sz ? v.di[31:16] : v.di[15:0],
                                       {~hb[1], ~hb[0], 1'b1}, cs, 1'b1, len});
            if (v.sz && v.be[1:0] != 2'b00)
                exp_halves.push_back('{a1, v.di[15:0],
                                       {~v.be[1], ~v.be[0], 1'b1}, cs, 1'b1, len});
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int dead_len);
        int    cs0;
        int    nexp;
        logic  got;
        ack_t  ak;
        half_t eh;
        half_t oh;
        @(negedge CLK);
        HOST_WE    = v.we;
        HOST_SZ    = v.sz;
        HOST_SPACE = v.sp;
        HOST_A     = v.a;
        HOST_BE    = v.be;
        HOST_DI    = v.di;
        resp_wait  = v.rwait;
        resp_d0    = v.d0;
        resp_d1    = v.d1;
        base       = halves_seen;
        cs0        = cs_cycles;
        e0         = cyc + 1;
        HOST_REQ   = 1'b1;
        model_halves(v, (dead_len > 0) ? dead_len : 2 + v.rwait);
        nexp = exp_halves.size();
        @(negedge CLK);
        chk($sformatf("%s.busy", tag), BUSY, 1);
        got = HOST_ACK;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            got = HOST_ACK;
        end
        HOST_REQ = 1'b0;
        chk($sformatf("%s.ack_seen", tag), got, 1);
        repeat (3) @(negedge CLK);
        chk($sformatf("%s.n_ack", tag), obs_acks.size(), 1);
        if (obs_acks.size() > 0) begin
            ak = obs_acks.pop_front();
            chk($sformatf("%s.err", tag), ak.err, v.exp_err);
            chk($sformatf("%s.lat", tag), ak.lat, v.exp_lat);
            if (v.chk_do) chk($sformatf("%s.host_do", tag), ak.dat, v.exp_do);
        end
        obs_acks.delete();
        chk($sformatf("%s.n_halves", tag), obs_halves.size(), nexp);
        while (exp_halves.size() > 0 && obs_halves.size() > 0) begin
            eh = exp_halves.pop_front();
            oh = obs_halves.pop_front();
            chk($sformatf("%s.a", tag), oh.a, eh.a);
            if (v.we) chk($sformatf("%s.do", tag), oh.dat, eh.dat);
            chk($sformatf("%s.strobes", tag), oh.st, eh.st);
            chk($sformatf("%s.cs", tag), oh.cs, eh.cs);
            chk($sformatf("%s.ackn_at_strobe", tag), oh.ackn, eh.ackn);
            chk($sformatf("%s.strobe_len", tag), oh.len, eh.len);
        end
        exp_halves.delete();
        obs_halves.delete();
        if (nexp == 0) chk($sformatf("%s.cs_idle", tag), cs_cycles - cs0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached without finishing");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        vec_t vt;
        vecs[0]  = '{0, 0, 2'b00, 17'h00010, 4'b0000, 32'h0,          16'h8001, 16'h0,    0, 1, 32'h0000_8001, 0, 5};
        vecs[1]  = '{1, 1, 2'b10, 17'h00100, 4'b1111, 32'hAABB_CCDD,  16'h0,    16'h0,    0, 0, 32'h0,         0, 10};
        vecs[2]  = '{1, 0, 2'b01, 17'h00020, 4'b0010, 32'h0000_1234,  16'h0,    16'h0,    0, 0, 32'h0,         0, 5};
        vecs[3]  = '{1, 1, 2'b10, 17'h00202, 4'b0011, 32'h1111_2222,  16'h0,    16'h0,    0, 0, 32'h0,         0, 5};
        vecs[4]  = '{0, 1, 2'b00, 17'h00041, 4'b0000, 32'h0,          16'h1234, 16'h5678, 0, 1, 32'h1234_5678, 0, 10};
        vecs[5]  = '{0, 0, 2'b11, 17'h00033, 4'b0011, 32'h0,          16'h7777, 16'h0,    0, 1, 32'h0,         1, 1};
        vecs[6]  = '{1, 0, 2'b00, 17'h00007, 4'b1100, 32'h0000_9999,  16'h0,    16'h0,    0, 0, 32'h0,         0, 1};
        vecs[7]  = '{0, 0, 2'b01, 17'h00011, 4'b0000, 32'h0,          16'hBEEF, 16'h0,    2, 1, 32'h0000_BEEF, 0, 7};
        vecs[8]  = '{1, 1, 2'b01, 17'h00010, 4'b1100, 32'hCAFE_0000,  16'h0,    16'h0,    0, 0, 32'h0,         0, 5};
        vecs[9]  = '{1, 1, 2'b10, 17'h1FFFE, 4'b0100, 32'h5A00_0000,  16'h0,    16'h0,    0, 0, 32'h0,         0, 5};
        vecs[10] = '{1, 1, 2'b11, 17'h00000, 4'b1111, 32'hFFFF_FFFF,  16'h0,    16'h0,    0, 1, 32'h0,         1, 1};
        vecs[11] = '{0, 1, 2'b10, 17'h1FFFF, 4'b0000, 32'h0,          16'hA5A5, 16'h5A5A, 1, 1, 32'hA5A5_5A5A, 0, 12};

        RST_N = 1'b0; HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_SZ = 1'b0;
        HOST_SPACE = 2'b00; HOST_A = '0; HOST_BE = '0; HOST_DI = '0;
        resp_dead = 1'b0; resp_wait = 0; resp_d0 = '0; resp_d1 = '0;
        base = 0; e0 = 0;

        repeat (3) @(negedge CLK);
        chk("reset.a", A, 0);
        chk("reset.do", DO, 0);
        chk("reset.host_do", HOST_DO, 0);
        chk("reset.strobes", {UWR_N, LWR_N, RD_N}, 3'b111);
        chk("reset.cs", {REG_CS_N, PAL_CS_N, DRAM_CS_N}, 3'b111);
        chk("reset.ack_err_busy", {HOST_ACK, HOST_ERR, BUSY}, 3'b000);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

        // Responder never acknowledges a 16-bit read.
        resp_dead = 1'b1;
        vt = '{0, 0, 2'b00, 17'h00005, 4'b0000, 32'h0, 16'h0, 16'h0, 0, 1, 32'h0000_FFFF, 1, 66};
        run_vec(vt, "timeout", 64);

        // Reset pulse while a strobe is low.
        @(negedge CLK);
        HOST_WE = 1'b0; HOST_SZ = 1'b0; HOST_SPACE = 2'b10; HOST_A = 17'h00abc;
        HOST_REQ = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_mid.in_strobe", RD_N, 0);
        RST_N = 1'b0;
        HOST_REQ = 1'b0;
        #1;
        chk("rst_mid.strobes", {UWR_N, LWR_N, RD_N}, 3'b111);
        chk("rst_mid.cs", {REG_CS_N, PAL_CS_N, DRAM_CS_N}, 3'b111);
        chk("rst_mid.busy_ack", {BUSY, HOST_ACK}, 2'b00);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        resp_dead = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_mid.no_ack", obs_acks.size(), 0);
        obs_halves.delete();
        run_vec(vecs[0], "post_rst", 0);

        chk("cs_stable_under_strobe", cs_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
